// File: rtl/v_hier_pkg.sv
// Shared types and constants for the 4-bit vector serial link.
//   rx_state_e : receiver FSM state encoding (3 bits)
//   IDLE_LEVEL : level of the serial line between frames
//   FRAME_LEN  : samples per frame for the default build (start + data + parity + stop)
package v_hier_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_BREAK  = 3'd4
  } rx_state_e;

  localparam logic        IDLE_LEVEL    = 1'b1;
  localparam int unsigned DEF_WIDTH     = 4;
  localparam int unsigned DEF_PARITY_EN = 1;
  localparam int unsigned FRAME_LEN     = 2 + DEF_WIDTH + DEF_PARITY_EN;

endpackage

// File: rtl/v_hier_vecrx_if.sv
// Serial-in / parallel-out bus of the vector receiver.
//   master : serial source and word consumer (drives sdi, sdi_en, qvec_ready)
//   slave  : the receiver (drives qvec, qvec_valid and the error pulses)
interface v_hier_vecrx_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             sdi;
  logic             sdi_en;
  logic             qvec_ready;
  logic [WIDTH-1:0] qvec;
  logic             qvec_valid;
  logic             par_err;
  logic             frm_err;
  logic             ovf_err;

  modport master (
    output sdi, sdi_en, qvec_ready,
    input  qvec, qvec_valid, par_err, frm_err, ovf_err
  );

  modport slave (
    input  sdi, sdi_en, qvec_ready,
    output qvec, qvec_valid, par_err, frm_err, ovf_err
  );
endinterface

// File: rtl/v_hier_vecfifo.sv
// 2-entry word FIFO with a registered head output.
//   clk, reset : clock, synchronous active-high reset
//   push_i     : write din_i (accepted when not full, or when a pop happens the same cycle)
//   pop_i      : consumer ready; pops only while non-empty
//   dout_o     : head word, holds its last value while empty
//   valid_o    : FIFO non-empty
//   full_o     : FIFO holds 2 words
module v_hier_vecfifo #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, full_q;
  logic             pop_c, push_c;

  // Next pointers, count and head word as seen after this edge
  always_comb begin
    pop_c    = pop_i && (count_q != 2'd0);
    push_c   = push_i && ((count_q != 2'd2) || pop_c);
    wr_ptr_d = wr_ptr_q ^ push_c;
    rd_ptr_d = rd_ptr_q ^ pop_c;
    count_d  = count_q;
    dout_d   = dout_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    // Head after a pop is the other stored entry, or the incoming word if none remains
    if (pop_c) begin
      if (count_q == 2'd2) dout_d = mem_q[~rd_ptr_q];
      else if (push_c)     dout_d = din_i;
    end else if (push_c && (count_q == 2'd0)) begin
      dout_d = din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= (count_d != 2'd0);
      full_q   <= (count_d == 2'd2);
    end
  end

  // Storage needs no reset; validity is tracked by the count
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = dout_q;
  assign valid_o = valid_q;
  assign full_o  = full_q;

endmodule

// File: rtl/v_hier_vecrx.sv
// Serial receiver for the vector link: deframes start/data/parity/stop samples
// into WIDTH-bit words, checks parity and stop bit, and queues good words.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of v_hier_vecrx_if (sdi/sdi_en in, qvec handshake out,
//                one-cycle par_err/frm_err/ovf_err pulses)
module v_hier_vecrx
  import v_hier_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          PARITY_EN = 1'b1
) (
  input logic            clk,
  input logic            reset,
  v_hier_vecrx_if.slave  bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             par_err_q, par_err_d;
  logic             frm_err_q, frm_err_d;
  logic             ovf_err_q, ovf_err_d;
  logic             push_c;
  logic             parity_ok_c;
  logic             fifo_valid, fifo_full;
  logic [WIDTH-1:0] fifo_dout;

  // Even parity: data and parity bit together must reduce to 0
  assign parity_ok_c = PARITY_EN ? ~(^shreg_q ^ par_q) : 1'b1;

  // Frame FSM; advances only on sdi_en samples
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    par_err_d = 1'b0;
    frm_err_d = 1'b0;
    ovf_err_d = 1'b0;
    push_c    = 1'b0;
    if (bus.sdi_en) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.sdi != IDLE_LEVEL) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end
        ST_DATA: begin
          shreg_d[cnt_q] = bus.sdi;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = PARITY_EN ? ST_PARITY : ST_STOP;
          else                            cnt_d   = cnt_q + CNT_W'(1);
        end
        ST_PARITY: begin
          par_d   = bus.sdi;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (bus.sdi) begin
            state_d = ST_IDLE;
            if (!parity_ok_c) begin
              par_err_d = 1'b1;
            end else if (fifo_full && !(fifo_valid && bus.qvec_ready)) begin
              ovf_err_d = 1'b1;
            end else begin
              push_c = 1'b1;
            end
          end else begin
            frm_err_d = 1'b1;
            state_d   = ST_BREAK;
          end
        end
        ST_BREAK: begin
          if (bus.sdi) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovf_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  v_hier_vecfifo #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_c),
    .din_i   (shreg_q),
    .pop_i   (bus.qvec_ready),
    .dout_o  (fifo_dout),
    .valid_o (fifo_valid),
    .full_o  (fifo_full)
  );

  assign bus.qvec       = fifo_dout;
  assign bus.qvec_valid = fifo_valid;
  assign bus.par_err    = par_err_q;
  assign bus.frm_err    = frm_err_q;
  assign bus.ovf_err    = ovf_err_q;

endmodule

// File: tb/tb_v_hier_vecrx.sv
// Directed self-checking bench for v_hier_vecrx.
module tb_v_hier_vecrx;
  import v_hier_pkg::*;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  v_hier_vecrx_if #(.WIDTH(4)) bus ();

  v_hier_vecrx #(.WIDTH(4), .PARITY_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame samples: start 0, data LSB first, parity, stop; qvec_ready only on the stop sample
  task automatic send_frame(input logic [3:0] d, input logic p, input logic s,
                            input logic rdy, input int gap);
    logic [FRAME_LEN-1:0] fr;
    fr = {s, p, d, 1'b0};
    for (int i = 0; i < FRAME_LEN; i++) begin
      bus.qvec_ready = (i == FRAME_LEN - 1) ? rdy : 1'b0;
      bus.sdi        = fr[i];
      bus.sdi_en     = 1'b1;
      tick();
      bus.sdi_en = 1'b0;
      if (i != FRAME_LEN - 1) begin
        bus.sdi = ~fr[i];
        repeat (gap) tick();
      end
    end
    bus.sdi        = 1'b1;
    bus.qvec_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.sdi    = 1'b1;
    bus.sdi_en = 1'b1;
    repeat (n) tick();
    bus.sdi_en = 1'b0;
  endtask

  task automatic pop_one();
    bus.qvec_ready = 1'b1;
    tick();
    bus.qvec_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.sdi = 1'b1; bus.sdi_en = 1'b0; bus.qvec_ready = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    total++; if (bus.qvec !== 4'h0) $display("FAIL reset_qvec: got %h want 0", bus.qvec); else passed++;
    total++; if (bus.qvec_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.qvec_valid); else passed++;
    total++; if ({bus.par_err, bus.frm_err, bus.ovf_err} !== 3'b000)
      $display("FAIL reset_errs: got %b want 000", {bus.par_err, bus.frm_err, bus.ovf_err}); else passed++;
  endtask

  task automatic test_single();
    send_frame(4'hD, 1'b1, 1'b1, 1'b0, 0);
    total++; if (bus.qvec !== 4'hD) $display("FAIL single_qvec: got %h want d", bus.qvec); else passed++;
    total++; if (bus.qvec_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", bus.qvec_valid); else passed++;
    total++; if ({bus.par_err, bus.frm_err, bus.ovf_err} !== 3'b000)
      $display("FAIL single_errs: got %b want 000", {bus.par_err, bus.frm_err, bus.ovf_err}); else passed++;
    pop_one();
    total++; if (bus.qvec_valid !== 1'b0) $display("FAIL single_pop_valid: got %b want 0", bus.qvec_valid); else passed++;
    total++; if (bus.qvec !== 4'hD) $display("FAIL single_hold_qvec: got %h want d", bus.qvec); else passed++;
  endtask

  task automatic test_parity();
    send_frame(4'h3, 1'b1, 1'b1, 1'b0, 0);
    total++; if (bus.par_err !== 1'b1) $display("FAIL parity_pulse: got %b want 1", bus.par_err); else passed++;
    total++; if (bus.qvec_valid !== 1'b0) $display("FAIL parity_valid: got %b want 0", bus.qvec_valid); else passed++;
    total++; if (bus.frm_err !== 1'b0) $display("FAIL parity_frm: got %b want 0", bus.frm_err); else passed++;
    idle(1);
    total++; if (bus.par_err !== 1'b0) $display("FAIL parity_one_cycle: got %b want 0", bus.par_err); else passed++;
  endtask

  task automatic test_framing();
    send_frame(4'h6, 1'b0, 1'b0, 1'b0, 0);
    total++; if (bus.frm_err !== 1'b1) $display("FAIL frame_pulse: got %b want 1", bus.frm_err); else passed++;
    total++; if (bus.par_err !== 1'b0) $display("FAIL frame_par: got %b want 0", bus.par_err); else passed++;
    bus.sdi = 1'b0; bus.sdi_en = 1'b1;
    tick();
    total++; if (bus.frm_err !== 1'b0) $display("FAIL frame_one_cycle: got %b want 0", bus.frm_err); else passed++;
    tick(); tick();
    idle(1);
    send_frame(4'hA, 1'b0, 1'b1, 1'b0, 0);
    total++; if (bus.qvec !== 4'hA) $display("FAIL frame_next_qvec: got %h want a", bus.qvec); else passed++;
    total++; if (bus.qvec_valid !== 1'b1) $display("FAIL frame_next_valid: got %b want 1", bus.qvec_valid); else passed++;
    total++; if ({bus.par_err, bus.frm_err} !== 2'b00)
      $display("FAIL frame_next_errs: got %b want 00", {bus.par_err, bus.frm_err}); else passed++;
    pop_one();
  endtask

  task automatic test_overflow();
    send_frame(4'h1, 1'b1, 1'b1, 1'b0, 0);
    total++; if (bus.qvec !== 4'h1) $display("FAIL ovf_first_qvec: got %h want 1", bus.qvec); else passed++;
    send_frame(4'h2, 1'b1, 1'b1, 1'b0, 0);
    total++; if (bus.ovf_err !== 1'b0) $display("FAIL ovf_second_noerr: got %b want 0", bus.ovf_err); else passed++;
    send_frame(4'h3, 1'b0, 1'b1, 1'b0, 0);
    total++; if (bus.ovf_err !== 1'b1) $display("FAIL ovf_pulse: got %b want 1", bus.ovf_err); else passed++;
    total++; if (bus.qvec !== 4'h1) $display("FAIL ovf_head: got %h want 1", bus.qvec); else passed++;
    idle(1);
    total++; if (bus.ovf_err !== 1'b0) $display("FAIL ovf_one_cycle: got %b want 0", bus.ovf_err); else passed++;
    pop_one();
    total++; if (bus.qvec !== 4'h2) $display("FAIL ovf_pop2_qvec: got %h want 2", bus.qvec); else passed++;
    total++; if (bus.qvec_valid !== 1'b1) $display("FAIL ovf_pop2_valid: got %b want 1", bus.qvec_valid); else passed++;
    pop_one();
    total++; if (bus.qvec_valid !== 1'b0) $display("FAIL ovf_drained: got %b want 0", bus.qvec_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    // one entry held: push and pop together replace the head
    send_frame(4'h7, 1'b1, 1'b1, 1'b0, 0);
    send_frame(4'h8, 1'b1, 1'b1, 1'b1, 0);
    total++; if (bus.qvec !== 4'h8) $display("FAIL b2b_one_qvec: got %h want 8", bus.qvec); else passed++;
    total++; if (bus.qvec_valid !== 1'b1) $display("FAIL b2b_one_valid: got %b want 1", bus.qvec_valid); else passed++;
    pop_one();
    total++; if (bus.qvec_valid !== 1'b0) $display("FAIL b2b_one_drain: got %b want 0", bus.qvec_valid); else passed++;
    // full: push accepted because of the simultaneous pop
    send_frame(4'h1, 1'b1, 1'b1, 1'b0, 0);
    send_frame(4'h2, 1'b1, 1'b1, 1'b0, 0);
    send_frame(4'h3, 1'b0, 1'b1, 1'b1, 0);
    total++; if (bus.ovf_err !== 1'b0) $display("FAIL b2b_full_ovf: got %b want 0", bus.ovf_err); else passed++;
    total++; if (bus.qvec !== 4'h2) $display("FAIL b2b_full_head2: got %h want 2", bus.qvec); else passed++;
    pop_one();
    total++; if (bus.qvec !== 4'h3) $display("FAIL b2b_full_head3: got %h want 3", bus.qvec); else passed++;
    total++; if (bus.qvec_valid !== 1'b1) $display("FAIL b2b_full_valid3: got %b want 1", bus.qvec_valid); else passed++;
    pop_one();
    total++; if (bus.qvec_valid !== 1'b0) $display("FAIL b2b_full_drain: got %b want 0", bus.qvec_valid); else passed++;
  endtask

  task automatic test_gapped_reset();
    send_frame(4'h9, 1'b0, 1'b1, 1'b0, 0);
    total++; if (bus.qvec !== 4'h9) $display("FAIL gap_pre_qvec: got %h want 9", bus.qvec); else passed++;
    // start bit plus 3 data bits of a frame, 1 sample every 3 cycles
    bus.sdi = 1'b0; bus.sdi_en = 1'b1; tick(); bus.sdi_en = 1'b0; bus.sdi = 1'b1; tick(); tick();
    bus.sdi = 1'b1; bus.sdi_en = 1'b1; tick(); bus.sdi_en = 1'b0; bus.sdi = 1'b0; tick(); tick();
    bus.sdi = 1'b0; bus.sdi_en = 1'b1; tick(); bus.sdi_en = 1'b0; bus.sdi = 1'b1; tick(); tick();
    bus.sdi = 1'b1; bus.sdi_en = 1'b1; tick(); bus.sdi_en = 1'b0; bus.sdi = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (bus.qvec_valid !== 1'b0) $display("FAIL gap_reset_valid: got %b want 0", bus.qvec_valid); else passed++;
    total++; if (bus.qvec !== 4'h0) $display("FAIL gap_reset_qvec: got %h want 0", bus.qvec); else passed++;
    total++; if ({bus.par_err, bus.frm_err, bus.ovf_err} !== 3'b000)
      $display("FAIL gap_reset_errs: got %b want 000", {bus.par_err, bus.frm_err, bus.ovf_err}); else passed++;
    send_frame(4'h5, 1'b0, 1'b1, 1'b0, 2);
    total++; if (bus.qvec !== 4'h5) $display("FAIL gap_frame_qvec: got %h want 5", bus.qvec); else passed++;
    total++; if (bus.qvec_valid !== 1'b1) $display("FAIL gap_frame_valid: got %b want 1", bus.qvec_valid); else passed++;
    total++; if ({bus.par_err, bus.frm_err, bus.ovf_err} !== 3'b000)
      $display("FAIL gap_frame_errs: got %b want 000", {bus.par_err, bus.frm_err, bus.ovf_err}); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    bus.sdi = 1'b1; bus.sdi_en = 1'b0; bus.qvec_ready = 1'b0;
    test_reset();
    test_single();
    test_parity();
    test_framing();
    test_overflow();
    test_back_to_back();
    test_gapped_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/v_hier_vecrx.md
# v_hier_vecrx

Serial receiver for the 4-bit vector link: deserializes framed bits from a single serial line back into parallel 4-bit vectors, checks parity and framing, and buffers received words in a 2-entry FIFO. The parallel side uses a valid/ready handshake. It is the receiving end of the vector serializer that sits beside `v_hier_sub` in the hierarchy test design.

## Interface
- `WIDTH`, 4: data bits per frame; `qvec` width.
- `PARITY_EN`, 1: 1 means a parity bit follows the data bits; 0 means there is no parity bit.
- `clk`  input  1  sole clock; everything is sampled on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `sdi`  input  1  serial data; idle level is 1.
- `sdi_en`  input  1  bit strobe; `sdi` is sampled only on cycles where `sdi_en`=1.
- `qvec`  output  WIDTH  data of the FIFO head word.
- `qvec_valid`  output  1  FIFO is non-empty.
- `qvec_ready`  input  1  consumer accepts the head word when `qvec_valid`=1.
- `par_err`  output  1  one-cycle pulse: frame dropped because of a parity mismatch.
- `frm_err`  output  1  one-cycle pulse: frame dropped because the stop bit was 0.
- `ovf_err`  output  1  one-cycle pulse: good frame dropped because the FIFO was full.

## Operation
- Frame format, in `sdi_en` samples:
  - start bit = 0;
  - WIDTH data bits, LSB first;
  - even parity bit over the data, only when PARITY_EN=1 (data ^ parity reduces to 0);
  - stop bit = 1.
- FSM states: IDLE, DATA, PARITY, STOP, BREAK.
  - IDLE: a sample of 0 goes to DATA with bit count 0. A sample of 1 stays in IDLE.
  - DATA: shift the sample into bit[count]. After sample WIDTH-1, go to PARITY if PARITY_EN=1, otherwise go to STOP.
  - PARITY: store the parity bit, then go to STOP.
  - STOP, sample of 1 with parity good:
    - FIFO has room: push the word and go to IDLE.
    - FIFO full: pulse `ovf_err`, drop the word, go to IDLE.
  - STOP, sample of 1 with parity bad: pulse `par_err`, go to IDLE.
  - STOP, sample of 0: pulse `frm_err`, go to BREAK. `par_err` is not also raised.
  - BREAK: wait for a sample of 1, then go to IDLE. A 0 sample here never starts a frame.
- The FSM advances only on `sdi_en`=1 cycles. The shift register, count and state all hold while `sdi_en`=0.
- FIFO: 2 entries with read and write pointers plus a count.
  - Pop happens when `qvec_valid` && `qvec_ready`.
  - Push on the same cycle as a pop is accepted even when the FIFO is full; no `ovf_err` in that case.
  - Push and pop on the same cycle with one entry held: count stays 1 and the new word becomes the head on the next cycle.
- `qvec` holds its last value while empty; it is not zeroed.
- Reset values:
  - state = IDLE, count = 0, FIFO empty, pointers = 0;
  - `qvec` = 0, `qvec_valid` = 0;
  - `par_err` = `frm_err` = `ovf_err` = 0.
- `reset` asserted in mid-frame abandons the partial frame and clears the FIFO. The first sample after reset is treated as IDLE.

## Timing
- All outputs are registered.
- A word pushed on the stop-bit sample edge appears on `qvec` with `qvec_valid`=1 on the following cycle (1-cycle latency from the stop sample).
- Error pulses assert on the cycle after the stop sample, for exactly one cycle.
- `qvec_ready` is combinationally usable. The pop takes effect at the edge, and the next head appears in the following cycle.
- Back-to-back frames (stop bit followed directly by the next start bit) are supported at full `sdi_en` rate, including `sdi_en` held at 1 continuously.

## Structure
- Shared package `v_hier_pkg`:
  - FSM state enum (IDLE, DATA, PARITY, STOP, BREAK), 3 bits;
  - localparam for the idle line level (1);
  - localparam for the frame length: 2 + WIDTH + PARITY_EN.
- Sub-module `v_hier_vecfifo`: 2-entry WIDTH-bit FIFO with push/pop/full/empty. It is instantiated once.
- The top level holds the FSM, the shift register and parity check, and the error pulse registers.

## Test plan
- Single frame with `sdi_en` always 1: send 0,1,0,1,1,1,1 (data 4'b1101 LSB first, parity 1, stop 1) with `qvec_ready`=0 → next cycle `qvec`=4'hD and `qvec_valid`=1; no error pulse.
- Parity error: data 4'h3, parity bit 1 → `par_err` pulses for 1 cycle, `qvec_valid` stays 0, FSM returns to IDLE.
- Framing error: frame with stop bit 0, followed by three 0 samples and then a 1, followed by a valid 4'hA frame → one `frm_err` pulse, no frame starts during BREAK, 4'hA is received.
- Overflow with `qvec_ready`=0: send 4'h1, 4'h2, 4'h3 → `ovf_err` on the third frame; `qvec` pops 1 then 2.
- Same-cycle push and pop on a full FIFO: raise `qvec_ready` on the stop-sample edge of a third frame → no `ovf_err`; words are delivered in order 1, 2, 3.
- Gapped `sdi_en` (1 in 3 cycles) plus `reset` asserted after 3 data bits → FIFO empty and outputs 0; the next full frame 4'h5 is received correctly.
